uart_rx_16x: RTL
================

// Module: uart_rx_16x
// PURPOSE
//  8N1 UART receiver. Consumes the 16x-baud strobe from the baud generator and the
//  raw RX pin. Delivers bytes to downstream logic through a one-byte valid/ready
//  holding register. Flags framing and overrun errors.
// PARAMETERS
//  DATA_BITS   8   payload bits per frame, LSB first
//  OVERSAMPLE  16  baud16_tick strobes per bit period
//  SYNC_STAGES 2   flops in the rx_pin metastability synchronizer (>=2)
// PORTS
//  sys_clk     in   1          system clock; all logic on its rising edge
//  rst         in   1          asynchronous reset, active-high
//  baud16_tick in   1          one-sys_clk-wide strobe at OVERSAMPLE*baud
//  rx_pin      in   1          asynchronous serial input; idle high
//  rx_data     out  DATA_BITS  received byte; stable while rx_valid=1
//  rx_valid    out  1          holding register full
//  rx_ready    in   1          consumer accepts byte when rx_valid & rx_ready
//  frame_err   out  1          one-cycle pulse: stop bit sampled low
//  overrun     out  1          one-cycle pulse: new byte lost, holding reg full
//  rx_busy     out  1          high from start detect until stop-bit decision
// BEHAVIOUR
//  Reset: sync flops=1, state=IDLE, counters=0; rx_data=0, rx_valid=0,
//   frame_err=0, overrun=0, rx_busy=0. Reset mid-frame drops the partial byte.
//  Counters advance only on cycles with baud16_tick=1. tick_cnt is 4 bits, wraps 15->0.
//  Bit decision = majority of synced rx at tick_cnt 7,8,9. Decision is made on tick 9.
//  FSM:
//   IDLE : synced rx=0 on a tick -> START, tick_cnt=0, rx_busy=1.
//   START: at tick 9, majority=1 -> IDLE (glitch rejected, no flag);
//          else continue. On tick 15 -> DATA, bit_cnt=0.
//   DATA : shift majority into shift reg MSB (LSB-first line order). After tick 15:
//          bit_cnt==DATA_BITS-1 -> STOP; else bit_cnt++.
//   STOP : at tick 9 decide, then -> IDLE immediately (half-bit early exit).
//          This tolerates back-to-back frames and +-~4% baud mismatch.
//          majority=1: deliver byte. majority=0: frame_err pulse, byte discarded.
//  Delivery, in the cycle after the STOP decision tick:
//   - rx_valid=0, or rx_ready=1 in the same cycle: load rx_data, rx_valid=1.
//   - rx_valid=1 and rx_ready=0: keep the old rx_data, pulse overrun, drop the new byte.
//  rx_valid clears on the rx_valid&rx_ready cycle unless a new byte loads in the
//   same cycle (rx_valid stays 1).
//  Error pulses are exactly one sys_clk wide and never asserted together.
//  rx_pin -> FSM latency is SYNC_STAGES cycles. The byte is visible 1 cycle after
//   the stop decision.
//  baud16_tick held high continuously = legal (max rate); no tick = FSM frozen.
// STRUCTURE
//  uart_pkg: rx FSM state enum (IDLE, START, DATA, STOP), OVERSAMPLE, sample-point
//   constants (7,8,9), and STOP decision tick; shared with future uart_tx_16x.
//  Sub-module bit_sync: SYNC_STAGES-deep flop chain, async reset to 1.
//  Rest in one always block for the FSM/counters plus the holding register.
// TESTING (bench: baud16_tick every 4 sys_clk, bit = 64 clk)
//  1 frame 0x55, rx_ready=1 -> rx_valid 1 cycle, rx_data=0x55, no error pulses.
//  2 rx_pin low 2 ticks then high -> rx_busy pulses, FSM back to IDLE,
//    rx_valid=0, no flags.
//  3 frame 0xA3 with stop bit=0 -> frame_err single pulse, rx_valid stays 0.
//  4 frames 0x12,0x34 back-to-back, rx_ready=0 -> rx_data=0x12, overrun pulse
//    at 2nd stop; then rx_ready=1 -> rx_valid falls.
//  5 rst asserted during bit 4 of 0xFF, released on idle line, then frame 0x0F
//    -> only 0x0F delivered.
//  6 bit period stretched +3% over 10 frames of random data -> all bytes match,
//    no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling rate and the
// tick positions used for majority-vote bit sampling.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMPLE_T0        = 4'd7;
    localparam logic [3:0] SAMPLE_T1        = 4'd8;
    localparam logic [3:0] SAMPLE_T2        = 4'd9;
    localparam logic [3:0] STOP_DECIDE_TICK = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_16x_bit_sync.sv
// Metastability synchronizer for the raw RX pin; resets to the idle (high) level.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 UART receiver on a 16x baud strobe, with a one-byte valid/ready holding
// register and single-cycle framing/overrun error pulses.
module uart_rx_16x #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 baud16_tick,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    import uart_pkg::*;

    localparam int         BCW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q,     state_d;
    logic [3:0]           tick_cnt_q,  tick_cnt_d;
    logic [BCW-1:0]       bit_cnt_q,   bit_cnt_d;
    logic [1:0]           samp_q,      samp_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q,   overrun_d;
    logic                 rx_busy_q,   rx_busy_d;
    logic                 maj;
    logic [DATA_BITS:0]   shift_ext;

    bit_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (sys_clk),
        .rst (rst),
        .d   (rx_pin),
        .q   (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // Samples at ticks 7 and 8 are held; tick 9 uses the live synced value.
        maj       = majority3(samp_q[0], samp_q[1], rx_s);
        shift_ext = {maj, shift_q};

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (baud16_tick) begin
            tick_cnt_d = (tick_cnt_q == LAST_TICK) ? 4'd0 : tick_cnt_q + 4'd1;
            if (tick_cnt_q == SAMPLE_T0) samp_d[0] = rx_s;
            if (tick_cnt_q == SAMPLE_T1) samp_d[1] = rx_s;

            case (state_q)
                IDLE: begin
                    tick_cnt_d = 4'd0;
                    if (!rx_s) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (tick_cnt_q == SAMPLE_T2 && maj) begin
                        state_d    = IDLE;
                        tick_cnt_d = 4'd0;
                    end else if (tick_cnt_q == LAST_TICK) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == SAMPLE_T2) begin
                        shift_d = shift_ext[DATA_BITS:1];
                    end
                    if (tick_cnt_q == LAST_TICK) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end
                end
                STOP: begin
                    // Leave half a bit early so a back-to-back start edge is not missed.
                    if (tick_cnt_q == STOP_DECIDE_TICK) begin
                        state_d    = IDLE;
                        tick_cnt_d = 4'd0;
                        if (!maj) begin
                            frame_err_d = 1'b1;
                        end else if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        rx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= '0;
            samp_q      <= 2'b11;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_busy_q   <= rx_busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = rx_busy_q;

endmodule
